// File: rtl/unlock_pkg.sv
// unlock_pkg: shared types and constants for the unlock sequence controller.
package unlock_pkg;

    localparam int unsigned KEY_W = 6;

    typedef enum logic [1:0] {
        CMD_NOP    = 2'd0,
        CMD_UNLOCK = 2'd1,
        CMD_LOCK   = 2'd2,
        CMD_RSVD   = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_CHECK    = 2'd1,
        ST_UNLOCKED = 2'd2,
        ST_LOCKOUT  = 2'd3
    } state_e;

endpackage

// File: rtl/unlock_timer.sv
// unlock_timer: loadable count-down timer that saturates at zero.
// tc_next flags that the count will be zero after the coming edge.
module unlock_timer #(
    parameter int unsigned W        = 8,
    parameter int unsigned LOAD_VAL = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic tc_next
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load wins over decrement; hold at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = W'(LOAD_VAL);
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
        tc_next = (count_d == '0);
    end

    // Count register, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/unlock_seq_ctrl.sv
// unlock_seq_ctrl: key-checked unlock sequencer driving a downstream lock
// register, with consecutive-failure lockout.
// Optional feature macro: AUTO_RELOCK_EN (idle auto-relock in UNLOCKED).
module unlock_seq_ctrl
    import unlock_pkg::*;
#(
    parameter logic [KEY_W-1:0] KEY         = 6'h2A,
    parameter int unsigned      MAX_FAIL    = 3,
    parameter int unsigned      LOCKOUT_CYC = 64,
    parameter int unsigned      RELOCK_CYC  = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_cmd,
    input  logic [KEY_W-1:0] req_key,
    output logic             resp_valid,
    output logic             resp_ok,
    output logic             lock_enable,
    output logic             lock_input,
    output logic             locked,
    output logic             lockout,
    output logic [2:0]       fail_count
);

    if ((MAX_FAIL < 1) || (MAX_FAIL > 7) || (LOCKOUT_CYC < 2) || (RELOCK_CYC < 2)) begin : g_bad_cfg
        $error("unlock_seq_ctrl: parameter out of range");
    end

    state_e           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [2:0]       fail_count_q, fail_count_d;
    logic             req_ready_q, req_ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_ok_q, resp_ok_d;
    logic             lock_enable_q, lock_enable_d;
    logic             lock_input_q, lock_input_d;
    logic             locked_q, locked_d;
    logic             lockout_q, lockout_d;

    logic             accept;
    cmd_e             cmd;
    logic [2:0]       fail_inc;
    logic             lockout_load;
    logic             lockout_tc_next;
    logic             relock_load;
    logic             relock_expire;
    logic             relock_tc_next;

    assign accept   = req_valid && req_ready_q;
    assign cmd      = cmd_e'(req_cmd);
    assign fail_inc = (fail_count_q == 3'd7) ? fail_count_q : fail_count_q + 3'd1;

    // Lockout timer: loaded with the full duration so tc_next marks the last LOCKOUT cycle.
    unlock_timer #(
        .W        ($clog2(LOCKOUT_CYC + 1)),
        .LOAD_VAL (LOCKOUT_CYC)
    ) u_lockout_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (lockout_load),
        .dec     (state_q == ST_LOCKOUT),
        .tc_next (lockout_tc_next)
    );

`ifdef AUTO_RELOCK_EN
    unlock_timer #(
        .W        ($clog2(RELOCK_CYC)),
        .LOAD_VAL (RELOCK_CYC - 1)
    ) u_relock_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (relock_load),
        .dec     (state_q == ST_UNLOCKED),
        .tc_next (relock_tc_next)
    );
    // req_ready is dropped only in the terminal UNLOCKED cycle, so it marks expiry.
    assign relock_expire = (state_q == ST_UNLOCKED) && !req_ready_q;
`else
    assign relock_tc_next = 1'b0;
    assign relock_expire  = 1'b0;
`endif

    // Next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        fail_count_d  = fail_count_q;
        resp_valid_d  = 1'b0;
        resp_ok_d     = 1'b0;
        lock_enable_d = 1'b0;
        lock_input_d  = 1'b0;
        lockout_load  = 1'b0;
        relock_load   = 1'b0;

        unique case (state_q)
            ST_LOCKED: begin
                if (accept) begin
                    unique case (cmd)
                        CMD_UNLOCK: begin
                            key_d   = req_key;
                            state_d = ST_CHECK;
                        end
                        CMD_LOCK: begin
                            resp_valid_d  = 1'b1;
                            resp_ok_d     = 1'b1;
                            lock_enable_d = 1'b1;
                        end
                        default: begin
                            resp_valid_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_CHECK: begin
                resp_valid_d = 1'b1;
                if (key_q == KEY) begin
                    resp_ok_d     = 1'b1;
                    lock_enable_d = 1'b1;
                    lock_input_d  = 1'b1;
                    fail_count_d  = '0;
                    relock_load   = 1'b1;
                    state_d       = ST_UNLOCKED;
                end else begin
                    fail_count_d = fail_inc;
                    if (fail_inc == 3'(MAX_FAIL)) begin
                        lockout_load = 1'b1;
                        state_d      = ST_LOCKOUT;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_UNLOCKED: begin
                if (accept) begin
                    resp_valid_d = 1'b1;
                    relock_load  = 1'b1;
                    unique case (cmd)
                        CMD_UNLOCK: resp_ok_d = 1'b1;
                        CMD_LOCK: begin
                            resp_ok_d     = 1'b1;
                            lock_enable_d = 1'b1;
                            relock_load   = 1'b0;
                            state_d       = ST_LOCKED;
                        end
                        default: resp_ok_d = 1'b0;
                    endcase
                end else if (relock_expire) begin
                    lock_enable_d = 1'b1;
                    state_d       = ST_LOCKED;
                end
            end
            ST_LOCKOUT: begin
                if (lockout_tc_next) begin
                    fail_count_d = '0;
                    state_d      = ST_LOCKED;
                end
            end
            default: state_d = ST_LOCKED;
        endcase

        req_ready_d = (state_d == ST_LOCKED) ||
                      ((state_d == ST_UNLOCKED) && !(relock_tc_next && !relock_load));
        locked_d    = (state_d != ST_UNLOCKED);
        lockout_d   = (state_d == ST_LOCKOUT);
    end

    // State and output registers; reset forces the downstream lock closed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_LOCKED;
            key_q         <= '0;
            fail_count_q  <= '0;
            req_ready_q   <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_ok_q     <= 1'b0;
            lock_enable_q <= 1'b1;
            lock_input_q  <= 1'b0;
            locked_q      <= 1'b1;
            lockout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_q         <= key_d;
            fail_count_q  <= fail_count_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_ok_q     <= resp_ok_d;
            lock_enable_q <= lock_enable_d;
            lock_input_q  <= lock_input_d;
            locked_q      <= locked_d;
            lockout_q     <= lockout_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_ok     = resp_ok_q;
    assign lock_enable = lock_enable_q;
    assign lock_input  = lock_input_q;
    assign locked      = locked_q;
    assign lockout     = lockout_q;
    assign fail_count  = fail_count_q;

endmodule

// File: tb/tb_unlock_seq_ctrl.sv
// tb_unlock_seq_ctrl: directed self-checking bench for unlock_seq_ctrl.
// Covers the AUTO_RELOCK_EN path when the macro is defined for the build.
module tb_unlock_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_cmd;
    logic [5:0] req_key;
    logic       resp_valid;
    logic       resp_ok;
    logic       lock_enable;
    logic       lock_input;
    logic       locked;
    logic       lockout;
    logic [2:0] fail_count;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    unlock_seq_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cmd     (req_cmd),
        .req_key     (req_key),
        .resp_valid  (resp_valid),
        .resp_ok     (resp_ok),
        .lock_enable (lock_enable),
        .lock_input  (lock_input),
        .locked      (locked),
        .lockout     (lockout),
        .fail_count  (fail_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for exactly one edge; caller ensures req_ready is high.
    task automatic send(input logic [1:0] cmd, input logic [5:0] key);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_key   = key;
        tick();
        req_valid = 1'b0;
        req_cmd   = 2'd0;
        req_key   = 6'd0;
    endtask

    task automatic unlock_good();
        send(2'd1, 6'h2A);
        tick();
    endtask

    initial begin
        int unsigned n;
        int unsigned bad_ready;
        int unsigned bad_resp;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_cmd   = 2'd0;
        req_key   = 6'd0;

        // Reset held three cycles: lock forced closed every cycle.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_lock_en", lock_enable, 1'b1);
            check("rst_lock_in", lock_input, 1'b0);
            check("rst_locked", locked, 1'b1);
            check("rst_ready", req_ready, 1'b0);
            check("rst_resp", resp_valid, 1'b0);
        end
        reset = 1'b0;
        tick();
        check("post_rst_lock_en", lock_enable, 1'b0);
        check("post_rst_ready", req_ready, 1'b1);
        check("post_rst_locked", locked, 1'b1);
        check("post_rst_fail", fail_count, 3'd0);
        check("post_rst_lockout", lockout, 1'b0);

        // Good unlock: CHECK at t+1, response at t+2.
        send(2'd1, 6'h2A);
        check("chk_ready", req_ready, 1'b0);
        check("chk_resp", resp_valid, 1'b0);
        tick();
        check("unl_resp", resp_valid, 1'b1);
        check("unl_ok", resp_ok, 1'b1);
        check("unl_lock_en", lock_enable, 1'b1);
        check("unl_lock_in", lock_input, 1'b1);
        check("unl_locked", locked, 1'b0);
        tick();
        check("unl2_resp", resp_valid, 1'b0);
        check("unl2_lock_en", lock_enable, 1'b0);
        check("unl2_lock_in", lock_input, 1'b0);
        check("unl2_locked", locked, 1'b0);
        check("unl2_ready", req_ready, 1'b1);

        // UNLOCK while unlocked: ok, no strobe, key ignored.
        send(2'd1, 6'h00);
        check("re_unl_resp", resp_valid, 1'b1);
        check("re_unl_ok", resp_ok, 1'b1);
        check("re_unl_lock_en", lock_enable, 1'b0);
        check("re_unl_locked", locked, 1'b0);

        // NOP and reserved while unlocked.
        send(2'd0, 6'h00);
        check("nop_u_resp", resp_valid, 1'b1);
        check("nop_u_ok", resp_ok, 1'b0);
        send(2'd3, 6'h2A);
        check("rsvd_u_resp", resp_valid, 1'b1);
        check("rsvd_u_ok", resp_ok, 1'b0);
        check("rsvd_u_locked", locked, 1'b0);

        // LOCK from unlocked.
        send(2'd2, 6'h00);
        check("lock_resp", resp_valid, 1'b1);
        check("lock_ok", resp_ok, 1'b1);
        check("lock_en", lock_enable, 1'b1);
        check("lock_in", lock_input, 1'b0);
        check("lock_locked", locked, 1'b1);
        tick();
        check("lock2_en", lock_enable, 1'b0);
        check("lock2_ready", req_ready, 1'b1);

        // Three bad keys: counts 1,2,3, then lockout.
        for (int i = 1; i <= 3; i++) begin
            send(2'd1, 6'h15);
            tick();
            check("bad_resp", resp_valid, 1'b1);
            check("bad_ok", resp_ok, 1'b0);
            check("bad_lock_en", lock_enable, 1'b0);
            check("bad_fail", fail_count, 32'(i));
            check("bad_lockout", lockout, (i == 3) ? 1'b1 : 1'b0);
            check("bad_ready", req_ready, (i == 3) ? 1'b0 : 1'b1);
            check("bad_locked", locked, 1'b1);
        end

        // Hammer a good UNLOCK throughout lockout; none may be taken.
        req_valid = 1'b1;
        req_cmd   = 2'd1;
        req_key   = 6'h2A;
        n         = 0;
        bad_ready = 0;
        bad_resp  = 0;
        while (lockout && (n < 200)) begin
            if (req_ready) bad_ready++;
            if (resp_valid && (n > 0)) bad_resp++;
            n++;
            @(posedge clk);
            if (!lockout) req_valid = 1'b0;
            #1;
        end
        req_valid = 1'b0;
        req_cmd   = 2'd0;
        req_key   = 6'd0;
        check("lockout_len", n, 64);
        check("lockout_ready_low", bad_ready, 0);
        check("lockout_no_resp", bad_resp, 0);
        check("lo_exit_fail", fail_count, 3'd0);
        check("lo_exit_ready", req_ready, 1'b1);
        check("lo_exit_locked", locked, 1'b1);
        check("lo_exit_lockout", lockout, 1'b0);

        // NOP while locked.
        send(2'd0, 6'h00);
        check("nop_l_resp", resp_valid, 1'b1);
        check("nop_l_ok", resp_ok, 1'b0);
        check("nop_l_lock_en", lock_enable, 1'b0);
        check("nop_l_locked", locked, 1'b1);

        // Reset during CHECK aborts with no response.
        send(2'd1, 6'h15);
        tick();
        check("pre_abort_fail", fail_count, 3'd1);
        send(2'd1, 6'h2A);
        reset = 1'b1;
        tick();
        check("abort_resp", resp_valid, 1'b0);
        check("abort_lock_en", lock_enable, 1'b1);
        check("abort_locked", locked, 1'b1);
        check("abort_fail", fail_count, 3'd0);
        reset = 1'b0;
        tick();
        check("abort2_resp", resp_valid, 1'b0);
        check("abort2_lock_en", lock_enable, 1'b0);
        check("abort2_locked", locked, 1'b1);
        check("abort2_ready", req_ready, 1'b1);

`ifdef AUTO_RELOCK_EN
        // Idle relock: the response cycle is UNLOCKED cycle 1; cycle 256 is terminal.
        unlock_good();
        n = 1;
        while (req_ready && (n < 400)) begin
            tick();
            n++;
        end
        check("relock_len", n, 256);
        check("relock_term_locked", locked, 1'b0);
        req_valid = 1'b1;
        req_cmd   = 2'd0;
        tick();
        req_valid = 1'b0;
        check("relock_lock_en", lock_enable, 1'b1);
        check("relock_lock_in", lock_input, 1'b0);
        check("relock_resp", resp_valid, 1'b0);
        check("relock_locked", locked, 1'b1);
        tick();
        check("relock2_resp", resp_valid, 1'b0);
        check("relock2_lock_en", lock_enable, 1'b0);

        // An accepted request restarts the relock count.
        unlock_good();
        for (int i = 0; i < 200; i++) tick();
        send(2'd0, 6'h00);
        check("restart_resp", resp_valid, 1'b1);
        n = 1;
        while (req_ready && (n < 400)) begin
            tick();
            n++;
        end
        check("restart_len", n, 256);
        tick();
        check("restart_lock_en", lock_enable, 1'b1);
        check("restart_locked", locked, 1'b1);
`else
        // Without auto-relock, UNLOCKED persists indefinitely.
        unlock_good();
        for (int i = 0; i < 300; i++) tick();
        check("persist_locked", locked, 1'b0);
        check("persist_ready", req_ready, 1'b1);
        check("persist_lock_en", lock_enable, 1'b0);
        send(2'd2, 6'h00);
        check("persist_lock_en2", lock_enable, 1'b1);
        check("persist_locked2", locked, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
